// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard logic: forwarding selects,
// writeback-select codes and stall-cause codes.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam logic [1:0] DM2REG_LOAD = 2'b01;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_LOAD = 2'd1;
  localparam logic [1:0] CAUSE_BR   = 2'd2;
  localparam logic [1:0] CAUSE_MD   = 2'd3;

  // r0 is hardwired to zero, so it never forms a dependency
  function automatic logic reg_dep(input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] wa_m,
                                         input logic              we_w,
                                         input logic [REG_AW-1:0] wa_w);
    if (we_m && reg_dep(src, wa_m)) return FWD_MEM;
    if (we_w && reg_dep(src, wa_w)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// HI/LO unit sequencer: reloads a countdown on every issue and reports busy
// until it reaches zero.
module md_seq #(
  parameter int unsigned MD_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hilo_we_i,
  output logic busy_o
);

  localparam int unsigned MD_W = (MD_LAT > 0) ? $clog2(MD_LAT + 1) : 1;

  logic [MD_W-1:0] md_cnt_q;
  logic [MD_W-1:0] md_cnt_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hilo_we_i)
      md_cnt_d = MD_W'(MD_LAT);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - MD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) md_cnt_q <= '0;
    else        md_cnt_q <= md_cnt_d;
  end

  assign busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection, forwarding selection, HI/LO sequencing and stall
// statistics for the five-stage pipeline.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic             branch_d,
  input  logic             jr_d,
  input  logic             hilo_acc_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       rf_wa_e,
  input  logic             we_reg_e,
  input  logic [1:0]       dm2reg_e,
  input  logic             hilo_we_e,
  input  logic [4:0]       rf_wa_m,
  input  logic             we_reg_m,
  input  logic [1:0]       dm2reg_m,
  input  logic [4:0]       rf_wa_w,
  input  logic             we_reg_w,
  input  logic             clr_cnt,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             forward_ad,
  output logic             forward_bd,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       stall_cause
);

  localparam logic MD_MULTI = (MD_LAT != 0);

  logic load_stall_c;
  logic br_stall_c;
  logic md_stall_c;
  logic stall_c;
  logic e_hits_c;
  logic m_load_hits_c;
  logic e_hits_rs_c;
  logic m_load_hits_rs_c;
  logic [1:0] cause_c;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]       stall_cause_q, stall_cause_d;

  md_seq #(.MD_LAT(MD_LAT)) u_md_seq (
    .clk       (clk),
    .rst_n     (rst),
    .hilo_we_i (hilo_we_e),
    .busy_o    (md_busy)
  );

  assign forward_ae = fwd_sel(rs_e, we_reg_m, rf_wa_m, we_reg_w, rf_wa_w);
  assign forward_be = fwd_sel(rt_e, we_reg_m, rf_wa_m, we_reg_w, rf_wa_w);
  assign forward_ad = we_reg_m & reg_dep(rs_d, rf_wa_m);
  assign forward_bd = we_reg_m & reg_dep(rt_d, rf_wa_m);

  assign load_stall_c = (dm2reg_e == DM2REG_LOAD) & we_reg_e &
                        (reg_dep(rs_d, rf_wa_e) | reg_dep(rt_d, rf_wa_e));

  // Branches compare in decode, so an ALU result still in E or a load in M
  // cannot be forwarded in time; jr only reads rs.
  assign e_hits_rs_c      = we_reg_e & reg_dep(rs_d, rf_wa_e);
  assign m_load_hits_rs_c = (dm2reg_m == DM2REG_LOAD) & reg_dep(rs_d, rf_wa_m);
  assign e_hits_c         = e_hits_rs_c | (we_reg_e & reg_dep(rt_d, rf_wa_e));
  assign m_load_hits_c    = m_load_hits_rs_c |
                            ((dm2reg_m == DM2REG_LOAD) & reg_dep(rt_d, rf_wa_m));
  assign br_stall_c = (branch_d & (e_hits_c | m_load_hits_c)) |
                      (jr_d & (e_hits_rs_c | m_load_hits_rs_c));

  assign md_stall_c = hilo_acc_d & (md_busy | (hilo_we_e & MD_MULTI));

  assign stall_c = load_stall_c | br_stall_c | md_stall_c;
  assign stall_f = stall_c;
  assign stall_d = stall_c;
  assign flush_e = stall_c;

  always_comb begin
    cause_c = CAUSE_NONE;
    if (load_stall_c)    cause_c = CAUSE_LOAD;
    else if (br_stall_c) cause_c = CAUSE_BR;
    else if (md_stall_c) cause_c = CAUSE_MD;
  end

  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    stall_cause_d = stall_cause_q;
    if (clr_cnt) begin
      stall_cnt_d   = '0;
      stall_cause_d = CAUSE_NONE;
    end else if (stall_c) begin
      stall_cause_d = cause_c;
      if (stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q   <= '0;
      stall_cause_q <= CAUSE_NONE;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      stall_cause_q <= stall_cause_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign stall_cause = stall_cause_q;

endmodule
